data_mem_responder: RTL and testbench

// - Data-memory responder for the pipelined RV32I core: executes the MEM-stage load/store requests issued by the pipeline controller.
// - Applies byte strobes shifted by address offset; sign/zero-extends load data per funct3.
// - Inserts configurable wait states and reports busy back to the controller for stalling.

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the pipeline controller (master) and the
// data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_f3;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              mem_busy;
  logic              misalign_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_f3,
    input  req_ready, rsp_valid, rsp_rdata, mem_busy, misalign_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_f3,
    output req_ready, rsp_valid, rsp_rdata, mem_busy, misalign_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I MEM stage.
// One access in flight at a time: IDLE -> (WAIT x WAIT_STATES) -> RESP -> IDLE.
// The store/load commits on the edge that enters RESP; rsp_valid is a
// one-cycle pulse in RESP.
// Optional feature macro: DM_MISALIGN_CHECK_EN. When defined, misaligned
// half/word accesses are flagged, stores suppressed and loads return 0.
// When undefined, half/word accesses are forced onto their aligned lane.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Access being committed: live bus when committing straight from IDLE
  // (zero wait states), otherwise the captured request.
  logic [3:0]        a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [2:0]        a_f3;

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             mis;
  logic [3:0]       strb;
  logic [31:0]      wshift, raw, lshift, ext;
  logic             commit;

  // Select the access source for the commit path
  always_comb begin
    if (state_q == S_IDLE) begin
      a_we    = bus.req_we;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
      a_f3    = bus.req_f3;
    end else begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_f3    = f3_q;
    end
  end

  // Decode lane offset, misalignment, strobes and extended load data
  always_comb begin
    idx = IDX_W'(32'(a_addr[ADDR_W-1:2]) % 32'(DEPTH_WORDS));
`ifdef DM_MISALIGN_CHECK_EN
    off = a_addr[1:0];
    case (a_f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a_addr[0];
      default: mis = |a_addr[1:0];
    endcase
`else
    mis = 1'b0;
    case (a_f3[1:0])
      2'b00:   off = a_addr[1:0];
      2'b01:   off = {a_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif
    // 4-bit shift: strobes pushed past bit 3 fall off, no wrap
    strb   = a_we << off;
    wshift = a_wdata << {off, 3'b000};
    raw    = mem[idx];
    lshift = raw >> {off, 3'b000};
    case (a_f3)
      3'b000:  ext = {{24{lshift[7]}}, lshift[7:0]};
      3'b001:  ext = {{16{lshift[15]}}, lshift[15:0]};
      3'b100:  ext = {24'h0, lshift[7:0]};
      3'b101:  ext = {16'h0, lshift[15:0]};
      default: ext = raw;
    endcase
  end

  // Next-state, capture and response-data logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_f3;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      mis_d   = mis;
      rdata_d = ((|a_we) || mis) ? 32'h0 : ext;
    end
  end

  // Control and response registers, async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      f3_q    <= 3'd0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Byte-lane store into the array; never cleared, blocked while in reset
  always_ff @(posedge clk) begin
    if (commit && !mis && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.mem_busy     = (state_q != S_IDLE);
  assign bus.rsp_valid    = (state_q == S_RESP);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.misalign_err = (state_q == S_RESP) && mis_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: dut0 has no wait states, dut1 has three.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        v   [2];
  logic [3:0]  we  [2];
  logic [15:0] ad  [2];
  logic [31:0] wd  [2];
  logic [2:0]  f3  [2];
  logic        rdy [2];
  logic        rv  [2];
  logic [31:0] rd  [2];
  logic        bsy [2];
  logic        me  [2];

  data_mem_responder_if #(.ADDR_W(16)) bus0 ();
  data_mem_responder_if #(.ADDR_W(16)) bus1 ();

  assign bus0.req_valid = v[0];  assign bus1.req_valid = v[1];
  assign bus0.req_we    = we[0]; assign bus1.req_we    = we[1];
  assign bus0.req_addr  = ad[0]; assign bus1.req_addr  = ad[1];
  assign bus0.req_wdata = wd[0]; assign bus1.req_wdata = wd[1];
  assign bus0.req_f3    = f3[0]; assign bus1.req_f3    = f3[1];
  assign rdy[0] = bus0.req_ready;    assign rdy[1] = bus1.req_ready;
  assign rv[0]  = bus0.rsp_valid;    assign rv[1]  = bus1.rsp_valid;
  assign rd[0]  = bus0.rsp_rdata;    assign rd[1]  = bus1.rsp_rdata;
  assign bsy[0] = bus0.mem_busy;     assign bsy[1] = bus1.mem_busy;
  assign me[0]  = bus0.misalign_err; assign me[1]  = bus1.misalign_err;

  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(16), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  // One full access; reports data, latency (negedges after accept),
  // misalign flag and ready at the response, and state one cycle later.
  task automatic access(input int d, input logic [3:0] w, input logic [15:0] a,
                        input logic [31:0] data, input logic [2:0] f,
                        output logic [31:0] r, output int lat, output logic mis,
                        output logic rdy_rsp, output logic vld_next,
                        output logic [31:0] r_next);
    @(negedge clk);
    v[d] = 1'b1; we[d] = w; ad[d] = a; wd[d] = data; f3[d] = f;
    @(negedge clk);
    v[d] = 1'b0;
    lat = 1;
    while (!rv[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rv[d]) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d addr %h: no rsp_valid within 40 cycles", d, a);
    end
    r = rd[d]; mis = me[d]; rdy_rsp = rdy[d];
    @(negedge clk);
    vld_next = rv[d]; r_next = rd[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks += 5;
      if (rdy[d] !== 1'b1)     begin errors++; $display("FAIL reset_ready dut%0d got %b exp 1", d, rdy[d]); end
      if (rv[d] !== 1'b0)      begin errors++; $display("FAIL reset_rsp_valid dut%0d got %b exp 0", d, rv[d]); end
      if (rd[d] !== 32'h0)     begin errors++; $display("FAIL reset_rdata dut%0d got %h exp 0", d, rd[d]); end
      if (bsy[d] !== 1'b0)     begin errors++; $display("FAIL reset_busy dut%0d got %b exp 0", d, bsy[d]); end
      if (me[d] !== 1'b0)      begin errors++; $display("FAIL reset_misalign dut%0d got %b exp 0", d, me[d]); end
    end
  endtask

  task automatic test_word();
    logic [31:0] r, rn; int lat; logic m, rr, vn;
    access(0, 4'b1111, 16'h0010, 32'hDEADBEEF, 3'b010, r, lat, m, rr, vn, rn);
    checks += 4;
    if (lat !== 1)       begin errors++; $display("FAIL sw_latency got %0d exp 1", lat); end
    if (r !== 32'h0)     begin errors++; $display("FAIL sw_rdata got %h exp 00000000", r); end
    if (rr !== 1'b0)     begin errors++; $display("FAIL resp_ready got %b exp 0", rr); end
    if (vn !== 1'b0)     begin errors++; $display("FAIL rsp_pulse_width got %b exp 0", vn); end
    access(0, 4'b0000, 16'h0010, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks += 3;
    if (r !== 32'hDEADBEEF)  begin errors++; $display("FAIL lw_10 got %h exp deadbeef", r); end
    if (lat !== 1)           begin errors++; $display("FAIL lw_latency got %0d exp 1", lat); end
    if (rn !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got %h exp deadbeef", rn); end
  endtask

  task automatic test_byte();
    logic [31:0] r, rn; int lat; logic m, rr, vn;
    access(0, 4'b0001, 16'h0013, 32'h00000080, 3'b000, r, lat, m, rr, vn, rn);
    access(0, 4'b0000, 16'h0013, 32'h0, 3'b000, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_13 got %h exp ffffff80", r); end
    access(0, 4'b0000, 16'h0013, 32'h0, 3'b100, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'h00000080) begin errors++; $display("FAIL lbu_13 got %h exp 00000080", r); end
    access(0, 4'b0000, 16'h0010, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb got %h exp 80adbeef", r); end
    access(0, 4'b0000, 16'h0011, 32'h0, 3'b000, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb_11 got %h exp ffffffbe", r); end
  endtask

  task automatic test_half();
    logic [31:0] r, rn; int lat; logic m, rr, vn;
    access(0, 4'b1111, 16'h0020, 32'h5555AAAA, 3'b010, r, lat, m, rr, vn, rn);
    access(0, 4'b0011, 16'h0022, 32'h00008001, 3'b001, r, lat, m, rr, vn, rn);
    access(0, 4'b0000, 16'h0022, 32'h0, 3'b001, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lh_22 got %h exp ffff8001", r); end
    access(0, 4'b0000, 16'h0022, 32'h0, 3'b101, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'h00008001) begin errors++; $display("FAIL lhu_22 got %h exp 00008001", r); end
    access(0, 4'b0000, 16'h0020, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'h8001AAAA) begin errors++; $display("FAIL lw_after_sh got %h exp 8001aaaa", r); end
    access(0, 4'b0000, 16'h0010, 32'h0, 3'b101, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_10 got %h exp 0000beef", r); end
  endtask

  task automatic test_wrap();
    logic [31:0] r, rn; int lat; logic m, rr, vn;
    access(0, 4'b0000, 16'h1010, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'h80ADBEEF) begin errors++; $display("FAIL wrap_1010 got %h exp 80adbeef", r); end
  endtask

  // req_valid held across two loads: second is taken only after RESP
  task automatic test_back_to_back();
    @(negedge clk);
    v[0] = 1'b1; we[0] = 4'b0000; ad[0] = 16'h0010; f3[0] = 3'b010;
    @(negedge clk);
    checks += 3;
    if (rv[0] !== 1'b1)        begin errors++; $display("FAIL b2b_first_vld got %b exp 1", rv[0]); end
    if (rd[0] !== 32'h80ADBEEF) begin errors++; $display("FAIL b2b_first_data got %h exp 80adbeef", rd[0]); end
    if (rdy[0] !== 1'b0)       begin errors++; $display("FAIL b2b_ready_in_resp got %b exp 0", rdy[0]); end
    @(negedge clk);
    checks += 2;
    if (rv[0] !== 1'b0)  begin errors++; $display("FAIL b2b_gap_vld got %b exp 0", rv[0]); end
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready got %b exp 1", rdy[0]); end
    ad[0] = 16'h0020;
    @(negedge clk);
    v[0] = 1'b0;
    checks += 2;
    if (rv[0] !== 1'b1)         begin errors++; $display("FAIL b2b_second_vld got %b exp 1", rv[0]); end
    if (rd[0] !== 32'h8001AAAA) begin errors++; $display("FAIL b2b_second_data got %h exp 8001aaaa", rd[0]); end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    logic [31:0] r, rn; int lat; logic m, rr, vn;
    logic exp_busy, exp_vld, exp_rdy;
    @(negedge clk);
    v[1] = 1'b1; we[1] = 4'b0000; ad[1] = 16'h0040; wd[1] = 32'h0; f3[1] = 3'b010;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      v[1] = 1'b0;
      exp_busy = (c <= 4); exp_vld = (c == 4); exp_rdy = (c == 5);
      checks += 3;
      if (bsy[1] !== exp_busy) begin errors++; $display("FAIL ws_busy c%0d got %b exp %b", c, bsy[1], exp_busy); end
      if (rv[1] !== exp_vld)   begin errors++; $display("FAIL ws_vld c%0d got %b exp %b", c, rv[1], exp_vld); end
      if (rdy[1] !== exp_rdy)  begin errors++; $display("FAIL ws_ready c%0d got %b exp %b", c, rdy[1], exp_rdy); end
    end
    access(1, 4'b1111, 16'h0030, 32'hAAAA5555, 3'b010, r, lat, m, rr, vn, rn);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_latency got %0d exp 4", lat); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r, rn; int lat; logic m, rr, vn;
    @(negedge clk);
    v[1] = 1'b1; we[1] = 4'b1111; ad[1] = 16'h0030; wd[1] = 32'h12345678; f3[1] = 3'b010;
    @(negedge clk);
    v[1] = 1'b0;
    checks++; if (bsy[1] !== 1'b1) begin errors++; $display("FAIL rmo_busy got %b exp 1", bsy[1]); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks += 2;
      if (rv[1] !== 1'b0)  begin errors++; $display("FAIL rmo_vld c%0d got %b exp 0", c, rv[1]); end
      if (bsy[1] !== 1'b0) begin errors++; $display("FAIL rmo_busy_rst c%0d got %b exp 0", c, bsy[1]); end
    end
    rst = 1'b0;
    access(1, 4'b0000, 16'h0030, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'hAAAA5555) begin errors++; $display("FAIL rmo_contents got %h exp aaaa5555", r); end
  endtask

  task automatic test_misalign();
    logic [31:0] r, rn; int lat; logic m, rr, vn;
    access(0, 4'b1111, 16'h0030, 32'h11223344, 3'b010, r, lat, m, rr, vn, rn);
    access(0, 4'b1111, 16'h0031, 32'hCAFEF00D, 3'b010, r, lat, m, rr, vn, rn);
`ifdef DM_MISALIGN_CHECK_EN
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_sw_err got %b exp 1", m); end
    access(0, 4'b0000, 16'h0030, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'h11223344) begin errors++; $display("FAIL mis_sw_suppressed got %h exp 11223344", r); end
    access(0, 4'b0000, 16'h0031, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks += 2;
    if (r !== 32'h0) begin errors++; $display("FAIL mis_lw_data got %h exp 00000000", r); end
    if (m !== 1'b1)  begin errors++; $display("FAIL mis_lw_err got %b exp 1", m); end
`else
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL mis_sw_err got %b exp 0", m); end
    access(0, 4'b0000, 16'h0030, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_sw_aligned got %h exp cafef00d", r); end
    access(0, 4'b0000, 16'h0031, 32'h0, 3'b010, r, lat, m, rr, vn, rn);
    checks += 2;
    if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_lw_aligned got %h exp cafef00d", r); end
    if (m !== 1'b0)         begin errors++; $display("FAIL mis_lw_err got %b exp 0", m); end
`endif
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; we[d] = 4'b0; ad[d] = 16'h0; wd[d] = 32'h0; f3[d] = 3'b0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_word();
    test_byte();
    test_half();
    test_wrap();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_op();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
